// File: rtl/alu_mul_seq_if.sv
// Request/response and ALU-drive bundle for the alu_mul_seq shift-and-add multiply sequencer.
// The abort input is present only when ALU_MUL_SEQ_ABORT_EN is defined.
interface alu_mul_seq_if;
    // start/done: start is sampled only while idle (busy=0) and is ignored
    // otherwise; done pulses for one cycle when product/prod_zero become valid.
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
`ifdef ALU_MUL_SEQ_ABORT_EN
    logic        abort;
`endif
    logic [3:0]  alu_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [7:0]  alu_result;
    logic        alu_c;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        prod_zero;

`ifdef ALU_MUL_SEQ_ABORT_EN
    modport slave (
        input  start, mcand, mplier, abort, alu_result, alu_c,
        output alu_sel, alu_a, alu_b, alu_cin, busy, done, product, prod_zero
    );
    modport master (
        output start, mcand, mplier, abort, alu_result, alu_c,
        input  alu_sel, alu_a, alu_b, alu_cin, busy, done, product, prod_zero
    );
`else
    modport slave (
        input  start, mcand, mplier, alu_result, alu_c,
        output alu_sel, alu_a, alu_b, alu_cin, busy, done, product, prod_zero
    );
    modport master (
        output start, mcand, mplier, alu_result, alu_c,
        input  alu_sel, alu_a, alu_b, alu_cin, busy, done, product, prod_zero
    );
`endif
endinterface

// File: rtl/alu_mul_seq.sv
// 8x8 unsigned multiply sequenced through the shared 8-bit ALU (ADD, then LSR of P_hi, then LSR of Q).
// Optional feature: define ALU_MUL_SEQ_ABORT_EN to add an abort input that cancels a running op.
module alu_mul_seq #(
    parameter logic [3:0] SEL_ADD  = 4'h0,
    parameter logic [3:0] SEL_LSR  = 4'hA,
    parameter logic [3:0] SEL_IDLE = 4'hE,
    parameter int         ITER     = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_mul_seq_if.slave bus,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHH  = 3'd2,
        SHL  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] LAST = 3'(ITER - 1);

    state_t     state;
    logic [7:0] m;
    logic [7:0] p_hi;
    logic [7:0] q;
    logic       cy;
    logic [2:0] cnt;
    logic       abort_req;

`ifdef ALU_MUL_SEQ_ABORT_EN
    assign abort_req = bus.abort && (state == ADD || state == SHH || state == SHL);
`else
    assign abort_req = 1'b0;
`endif

    assign dbg_state = state;

    // ALU drive is registered: each transition loads the operands the next
    // state needs, taken from the values being latched on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            m             <= 8'h00;
            p_hi          <= 8'h00;
            q             <= 8'h00;
            cy            <= 1'b0;
            cnt           <= 3'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.product   <= 16'h0000;
            bus.prod_zero <= 1'b0;
            bus.alu_sel   <= SEL_IDLE;
            bus.alu_a     <= 8'h00;
            bus.alu_b     <= 8'h00;
            bus.alu_cin   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (abort_req) begin
                state         <= IDLE;
                bus.busy      <= 1'b0;
                bus.product   <= 16'h0000;
                bus.prod_zero <= 1'b0;
                bus.alu_sel   <= SEL_IDLE;
                bus.alu_a     <= 8'h00;
                bus.alu_b     <= 8'h00;
                bus.alu_cin   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            m           <= bus.mcand;
                            q           <= bus.mplier;
                            p_hi        <= 8'h00;
                            cy          <= 1'b0;
                            cnt         <= 3'd0;
                            state       <= ADD;
                            bus.busy    <= 1'b1;
                            bus.alu_sel <= SEL_ADD;
                            bus.alu_a   <= 8'h00;
                            bus.alu_b   <= bus.mplier[0] ? bus.mcand : 8'h00;
                            bus.alu_cin <= 1'b0;
                        end
                    end
                    ADD: begin
                        // Carry-out rides in cy and enters P_hi[7] on the next shift.
                        p_hi        <= bus.alu_result;
                        cy          <= bus.alu_c;
                        state       <= SHH;
                        bus.alu_sel <= SEL_LSR;
                        bus.alu_a   <= bus.alu_result;
                        bus.alu_b   <= 8'h00;
                        bus.alu_cin <= bus.alu_c;
                    end
                    SHH: begin
                        p_hi        <= bus.alu_result;
                        cy          <= bus.alu_c;
                        state       <= SHL;
                        bus.alu_sel <= SEL_LSR;
                        bus.alu_a   <= q;
                        bus.alu_b   <= 8'h00;
                        bus.alu_cin <= bus.alu_c;
                    end
                    SHL: begin
                        q  <= bus.alu_result;
                        cy <= 1'b0;
                        if (cnt == LAST) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.product   <= {p_hi, bus.alu_result};
                            bus.prod_zero <= ({p_hi, bus.alu_result} == 16'h0000);
                            bus.alu_sel   <= SEL_IDLE;
                            bus.alu_a     <= 8'h00;
                            bus.alu_b     <= 8'h00;
                            bus.alu_cin   <= 1'b0;
                        end else begin
                            cnt         <= cnt + 3'd1;
                            state       <= ADD;
                            bus.alu_sel <= SEL_ADD;
                            bus.alu_a   <= p_hi;
                            bus.alu_b   <= bus.alu_result[0] ? m : 8'h00;
                            bus.alu_cin <= 1'b0;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.alu_sel <= SEL_IDLE;
                        bus.alu_a   <= 8'h00;
                        bus.alu_b   <= 8'h00;
                        bus.alu_cin <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: models the shared ALU, applies a vector table, corner sequences and random ops.
module tb_alu_mul_seq;
    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    alu_mul_seq_if bus ();

    alu_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU: ADD with carry, LSR through cIn, MOV of b
    always_comb begin
        bus.alu_result = 8'h00;
        bus.alu_c      = 1'b0;
        case (bus.alu_sel)
            4'h0: {bus.alu_c, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_cin};
            4'hA: begin
                bus.alu_result = {bus.alu_cin, bus.alu_a[7:1]};
                bus.alu_c      = bus.alu_a[0];
            end
            4'hE: bus.alu_result = bus.alu_b;
            default: ;
        endcase
    end

    // scoreboard
    logic [15:0] exp_q[$];
    logic [15:0] last_prod;
    int          n_pass;
    int          n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Runs one op starting at the current negedge; inj1/inj2 are cycle numbers at
    // which a spurious 3*3 start is presented (0 = none). Ends at cycle 26 (idle).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int inj1, input int inj2);
        int done_n;
        int done_cnt;
        int busy_cnt;
        logic [15:0] exp;
        exp_q.push_back(16'(a) * 16'(b));
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_n   = 0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (n == 10) check("product_hold", 32'(bus.product), 32'(last_prod));
            if (bus.done) begin
                done_cnt++;
                done_n = n;
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    check("product", 32'(bus.product), 32'(exp));
                    check("prod_zero", 32'(bus.prod_zero), 32'(exp == 16'h0000));
                    last_prod = exp;
                end else begin
                    check("unexpected_done", 32'(done_cnt), 32'(0));
                end
            end
            if (n == inj1 || n == inj2) begin
                bus.start  = 1'b1;
                bus.mcand  = 8'd3;
                bus.mplier = 8'd3;
            end else begin
                bus.start  = 1'b0;
                bus.mcand  = a;
                bus.mplier = b;
            end
        end
        check("done_latency", 32'(done_n), 32'(25));
        check("done_count", 32'(done_cnt), 32'(1));
        check("busy_cycles", 32'(busy_cnt), 32'(25));
        check("idle_after", 32'(dbg_state), 32'(0));
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        n_pass     = 0;
        n_total    = 0;
        last_prod  = 16'h0000;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mcand  = 8'h00;
        bus.mplier = 8'h00;
`ifdef ALU_MUL_SEQ_ABORT_EN
        bus.abort  = 1'b0;
`endif
        tbl[0] = '{8'd13, 8'd11, 16'h008F};
        tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{8'h00, 8'hA5, 16'h0000};
        tbl[3] = '{8'h80, 8'h02, 16'h0100};
        tbl[4] = '{8'h01, 8'hFF, 16'h00FF};
        tbl[5] = '{8'hFF, 8'h01, 16'h00FF};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_product", 32'(bus.product), 32'(0));
        check("rst_prod_zero", 32'(bus.prod_zero), 32'(0));
        check("rst_alu_sel", 32'(bus.alu_sel), 32'(4'hE));
        check("rst_alu_ab", 32'({bus.alu_a, bus.alu_b, 7'd0, bus.alu_cin}), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // table-driven vectors (back-to-back)
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, 0, 0);
            check("tbl_product", 32'(bus.product), 32'(tbl[i].exp));
        end

`ifdef ALU_MUL_SEQ_ABORT_EN
        // abort mid-operation
        run_op(8'h00, 8'h5A, 0, 0);
        bus.start  = 1'b1;
        bus.mcand  = 8'd200;
        bus.mplier = 8'd200;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= 12; n++) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_state", 32'(dbg_state), 32'(0));
        check("abort_product", 32'(bus.product), 32'(0));
        check("abort_prod_zero", 32'(bus.prod_zero), 32'(0));
        begin
            int dn;
            dn = 0;
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (bus.done) dn++;
            end
            check("abort_no_done", 32'(dn), 32'(0));
        end
        last_prod = 16'h0000;
        run_op(8'd200, 8'd200, 0, 0);
        check("after_abort", 32'(bus.product), 32'(16'h9C40));
`endif

        // starts while busy (mid-op, last SHL cycle, DONE cycle) are ignored
        run_op(8'd7, 8'd9, 5, 24);
        check("ignored_start", 32'(bus.product), 32'(16'h003F));
        run_op(8'd7, 8'd9, 25, 0);
        check("ignored_start_done", 32'(bus.product), 32'(16'h003F));

        // asynchronous reset mid-operation
        bus.start  = 1'b1;
        bus.mcand  = 8'd9;
        bus.mplier = 8'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= 10; n++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'(0));
        check("arst_done", 32'(bus.done), 32'(0));
        check("arst_product", 32'(bus.product), 32'(0));
        check("arst_state", 32'(dbg_state), 32'(0));
        check("arst_alu_sel", 32'(bus.alu_sel), 32'(4'hE));
        @(negedge clk);
        rst = 1'b0;
        last_prod = 16'h0000;
        @(negedge clk);
        run_op(8'd2, 8'd3, 0, 0);
        check("after_arst", 32'(bus.product), 32'(16'h0006));

        // randomized ops against a*b
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i == 0) rb = 8'h00;
            run_op(ra, rb, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
